// File: rtl/ahb_xfer_scheduler.sv
// ahb_xfer_scheduler: arbitrates single-word AHB reads and writebacks for one
// frame job, one transaction outstanding at a time, round-robin between
// read and write when both are eligible.
// Optional feature: define SCHED_TIMEOUT_EN to add an 8-bit wait-state
// watchdog that aborts a stalled transaction and raises the sticky err flag.
module ahb_xfer_scheduler (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [15:0] img_width,
    input  logic [15:0] img_height,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic        read_complete,
    input  logic        write_complete,
    output logic        re,
    output logic        we,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ARB     = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [32:0] total_words;
    logic [32:0] px_round;
    logic        rd_pri;
    logic        start_ok;
    logic        rd_elig;
    logic        wr_elig;
    logic        all_done;
    logic        grant_rd;
    logic        grant_wr;
    logic        wd_expire;

    // Pixel count rounded up to whole 32-bit words; 33 bits so 0xFFFF^2+3 fits.
    assign px_round = 33'(img_width) * 33'(img_height) + 33'd3;

    assign start_ok = (state == IDLE) && start;
    assign rd_elig  = rd_req && ({1'b0, rd_count} < total_words);
    // A word can only be written back once it has been read in.
    assign wr_elig  = wr_req && (wr_count < rd_count);
    assign all_done = ({1'b0, rd_count} == total_words) &&
                      ({1'b0, wr_count} == total_words);

    // Eligibility already excludes the finished case, so no extra gating.
    assign grant_rd = (state == ARB) && rd_elig && (rd_pri || !wr_elig);
    assign grant_wr = (state == ARB) && wr_elig && (!rd_pri || !rd_elig);

    assign re   = grant_rd;
    assign we   = grant_wr;
    assign busy = (state != IDLE);
    assign done = (state == FINISH);

`ifdef SCHED_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       err_q;

    // The watchdog holds cycles since the strobe; stepping from 254 to 255
    // without a completion ends the transaction.
    assign wd_expire = (((state == RD_WAIT) && !read_complete) ||
                        ((state == WR_WAIT) && !write_complete)) &&
                       (wd_cnt == 8'd254);

    // Watchdog: loaded on the issuing strobe, advances while waiting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            wd_cnt <= '0;
        else if (grant_rd || grant_wr)
            wd_cnt <= 8'd1;
        else if ((state == RD_WAIT) || (state == WR_WAIT))
            wd_cnt <= wd_cnt + 8'd1;
    end

    // Sticky timeout flag, cleared only by reset or a new accepted job.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            err_q <= 1'b0;
        else if (start_ok)
            err_q <= 1'b0;
        else if (wd_expire)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state selection for the job sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARB;
            ARB: begin
                if (all_done)      state_nxt = FINISH;
                else if (grant_rd) state_nxt = RD_WAIT;
                else if (grant_wr) state_nxt = WR_WAIT;
            end
            RD_WAIT: begin
                if (read_complete)  state_nxt = ARB;
                else if (wd_expire) state_nxt = FINISH;
            end
            WR_WAIT: begin
                if (write_complete) state_nxt = ARB;
                else if (wd_expire) state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any job immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Job size and completed-word counters; held after done until next start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_count    <= '0;
            wr_count    <= '0;
            total_words <= '0;
        end else if (start_ok) begin
            rd_count    <= '0;
            wr_count    <= '0;
            total_words <= px_round >> 2;
        end else begin
            if ((state == RD_WAIT) && read_complete)
                rd_count <= rd_count + 32'd1;
            if ((state == WR_WAIT) && write_complete)
                wr_count <= wr_count + 32'd1;
        end
    end

    // Round-robin pointer: the type not granted last gets priority next time.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            rd_pri <= 1'b1;
        else if (grant_rd)
            rd_pri <= 1'b0;
        else if (grant_wr)
            rd_pri <= 1'b1;
    end

endmodule

// File: tb/tb_ahb_xfer_scheduler.sv
// tb_ahb_xfer_scheduler: randomized and directed bench for ahb_xfer_scheduler
// with a transaction-level reference model and an emulated AHB wrapper.
`timescale 1ns/1ps
module tb_ahb_xfer_scheduler;

    logic        tb_clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic        rd_req;
    logic        wr_req;
    logic        read_complete;
    logic        write_complete;
    logic        re;
    logic        we;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

`ifdef SCHED_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    always #5 tb_clk = ~tb_clk;

    ahb_xfer_scheduler dut (
        .clk            (tb_clk),
        .n_rst          (n_rst),
        .start          (start),
        .img_width      (img_width),
        .img_height     (img_height),
        .rd_req         (rd_req),
        .wr_req         (wr_req),
        .read_complete  (read_complete),
        .write_complete (write_complete),
        .re             (re),
        .we             (we),
        .rd_count       (rd_count),
        .wr_count       (wr_count),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // Reference model: job active, finishing, which transfer is outstanding
    // (0 none, 1 read, 2 write), cycles since the strobe, counts and target.
    bit     m_active  = 0;
    bit     m_fin     = 0;
    bit     m_err     = 0;
    bit     m_rdfirst = 1;
    int     m_out     = 0;
    int     m_wait    = 0;
    longint m_rd      = 0;
    longint m_wr      = 0;
    longint m_total   = 0;

    // Monitors for the directed checks.
    int ev_q[$];
    int ev_cyc[$];
    int done_cyc  = -1;
    int start_cyc = -1;
    int busy_cnt  = 0;
    bit done_err  = 0;

    always @(posedge tb_clk) cyc_n++;

    // Per-cycle compare against the model, then advance the model.
    always @(negedge tb_clk) begin
        bit     e_re, e_we, e_busy, e_done, e_err, rd_ok, wr_ok, got;
        longint e_rd, e_wr;
        e_re = 0; e_we = 0;
        if (!n_rst) begin
            e_busy = 0; e_done = 0; e_err = 0; e_rd = 0; e_wr = 0;
            m_active = 0; m_fin = 0; m_err = 0; m_rdfirst = 1; m_out = 0;
            m_wait = 0; m_rd = 0; m_wr = 0; m_total = 0;
        end else begin
            e_busy = m_active; e_done = m_fin; e_err = m_err;
            e_rd = m_rd; e_wr = m_wr;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_rd = 0; m_wr = 0; m_err = 0; m_out = 0;
                    m_total = (longint'(img_width) * longint'(img_height) + 3) / 4;
                    start_cyc = cyc_n;
                end
            end else if (m_fin) begin
                m_fin = 0; m_active = 0;
            end else if (m_out == 0) begin
                if (m_rd == m_total && m_wr == m_total) begin
                    m_fin = 1;
                end else begin
                    rd_ok = rd_req && (m_rd < m_total);
                    wr_ok = wr_req && (m_wr < m_rd);
                    if (rd_ok && (!wr_ok || m_rdfirst)) begin
                        e_re = 1; m_out = 1; m_rdfirst = 0; m_wait = 1;
                    end else if (wr_ok) begin
                        e_we = 1; m_out = 2; m_rdfirst = 1; m_wait = 1;
                    end
                end
            end else begin
                got = (m_out == 1) ? read_complete : write_complete;
                if (got) begin
                    if (m_out == 1) m_rd++; else m_wr++;
                    m_out = 0;
                end else if (TMO && (m_wait + 1 == 255)) begin
                    m_fin = 1; m_err = 1; m_out = 0;
                end else begin
                    m_wait++;
                end
            end
        end
        checks++;
        if ({re, we, busy, done, err} !== {e_re, e_we, e_busy, e_done, e_err} ||
            rd_count !== 32'(e_rd) || wr_count !== 32'(e_wr)) begin
            failures++;
            $display("FAIL cycle_cmp cyc=%0d got re=%b we=%b busy=%b done=%b err=%b rd=%0d wr=%0d expected re=%b we=%b busy=%b done=%b err=%b rd=%0d wr=%0d",
                     cyc_n, re, we, busy, done, err, rd_count, wr_count,
                     e_re, e_we, e_busy, e_done, e_err, e_rd, e_wr);
        end
        if (re) begin ev_q.push_back(1); ev_cyc.push_back(cyc_n); end
        if (we) begin ev_q.push_back(2); ev_cyc.push_back(cyc_n); end
        if (done) begin done_cyc = cyc_n; done_err = err; end
        if (busy) busy_cnt++;
    end

    // Emulated AHB wrapper: completes the outstanding transfer after a delay,
    // optionally toggling the other completion line as noise.
    bit auto_resp = 0;
    bit noise_en  = 0;
    bit rand_dly  = 0;
    int fix_dly   = 2;
    int wcnt      = 0;
    int wdly      = 0;
    always @(posedge tb_clk) begin
        #1;
        if (auto_resp) begin
            read_complete  = 0;
            write_complete = 0;
            if (m_out == 0) begin
                wcnt = 0;
                if (noise_en) begin
                    read_complete  = ($urandom_range(0, 3) == 0);
                    write_complete = ($urandom_range(0, 3) == 0);
                end
            end else begin
                if (wcnt == 0) wdly = rand_dly ? int'($urandom_range(1, 4)) : fix_dly;
                wcnt++;
                if (wcnt >= wdly) begin
                    if (m_out == 1) read_complete = 1; else write_complete = 1;
                end
                if (noise_en && $urandom_range(0, 2) == 0) begin
                    if (m_out == 1) write_complete = 1; else read_complete = 1;
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge tb_clk); #1; end
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic do_start(input int w, input int h);
        img_width  = 16'(w);
        img_height = 16'(h);
        start = 1;
        cyc();
        start = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy === 1'b1 && k < budget) begin cyc(); k++; end
        checks++;
        if (k >= budget) begin
            failures++;
            $display("FAIL %s_wait busy still %b after %0d cycles, expected 0", name, busy, k);
        end
    endtask

    task automatic clear_mon();
        ev_q.delete(); ev_cyc.delete();
        done_cyc = -1; start_cyc = -1; busy_cnt = 0; done_err = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int code;
        int nev;
        n_rst = 0; start = 0; img_width = 0; img_height = 0;
        rd_req = 0; wr_req = 0; read_complete = 0; write_complete = 0;
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_re_we", {re, we}, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_counts", rd_count + wr_count, 0);
        n_rst = 1;
        cyc(2);

        // 4x2 image, both requests held, completion 2 cycles after each strobe.
        clear_mon();
        rd_req = 1; wr_req = 1; auto_resp = 1; fix_dly = 2; rand_dly = 0; noise_en = 0;
        do_start(4, 2);
        wait_idle(100, "t1");
        chk("t1_nstrobe", ev_q.size(), 4);
        code = 0;
        foreach (ev_q[i]) code = code * 10 + ev_q[i];
        chk("t1_order", code, 1212);
        chk("t1_done_lat", done_cyc - start_cyc, 14);
        chk("t1_rd", rd_count, 2);
        chk("t1_wr", wr_count, 2);

        // Zero-sized frame.
        clear_mon();
        do_start(0, 7);
        wait_idle(20, "t2");
        chk("t2_done_lat", done_cyc - start_cyc, 2);
        chk("t2_nstrobe", ev_q.size(), 0);
        chk("t2_busy_cycles", busy_cnt, 2);

        // 3x3 image: writes wait for the first read.
        clear_mon();
        rd_req = 0; wr_req = 1;
        do_start(3, 3);
        cyc(10);
        chk("t3_no_we", ev_q.size(), 0);
        chk("t3_busy", busy, 1);
        rd_req = 1;
        wait_idle(200, "t3");
        chk("t3_first_read", (ev_q.size() > 0) ? ev_q[0] : 0, 1);
        chk("t3_nstrobe", ev_q.size(), 6);
        chk("t3_rd", rd_count, 3);
        chk("t3_wr", wr_count, 3);

        // start while busy is ignored.
        clear_mon();
        do_start(4, 2);
        cyc(3);
        img_width = 16'd100; img_height = 16'd100; start = 1;
        cyc();
        start = 0;
        wait_idle(200, "t4");
        chk("t4_nstrobe", ev_q.size(), 4);
        chk("t4_rd", rd_count, 2);
        chk("t4_wr", wr_count, 2);

        // Reset during RD_WAIT with one word already read.
        clear_mon();
        auto_resp = 0; read_complete = 0; write_complete = 0;
        rd_req = 1; wr_req = 0;
        do_start(16, 16);
        cyc();
        read_complete = 1;
        cyc();
        read_complete = 0;
        cyc();
        chk("t5_pre_rd", rd_count, 1);
        chk("t5_pre_busy", busy, 1);
        #2 n_rst = 0;
        #1;
        chk("t5_rst_strobes", {re, we, done, err}, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rd", rd_count, 0);
        chk("t5_rst_wr", wr_count, 0);
        nev = ev_q.size();
        cyc();
        n_rst = 1;
        cyc();
        read_complete = 1;
        cyc();
        read_complete = 0;
        cyc(2);
        chk("t5_post_rd", rd_count, 0);
        chk("t5_post_busy", busy, 0);
        chk("t5_post_strobes", ev_q.size(), nev);

`ifdef SCHED_TIMEOUT_EN
        // Read never completes: watchdog aborts the job.
        clear_mon();
        auto_resp = 0; rd_req = 1; wr_req = 0;
        do_start(4, 1);
        wait_idle(400, "t6");
        chk("t6_nstrobe", ev_q.size(), 1);
        chk("t6_tmo_lat", done_cyc - ((ev_cyc.size() > 0) ? ev_cyc[0] : 0), 255);
        chk("t6_err_at_done", done_err, 1);
        cyc(3);
        chk("t6_err_sticky", err, 1);
        wr_req = 1; auto_resp = 1;
        do_start(4, 1);
        chk("t6_err_clear", err, 0);
        wait_idle(100, "t6b");
        chk("t6_rd", rd_count, 1);
        chk("t6_wr", wr_count, 1);
`else
        // Without the watchdog the wait state persists indefinitely.
        clear_mon();
        auto_resp = 0; rd_req = 1; wr_req = 0;
        do_start(4, 1);
        cyc(300);
        chk("t6_still_busy", busy, 1);
        chk("t6_no_done", done_cyc, -1);
        chk("t6_no_err", err, 0);
        read_complete = 1;
        cyc();
        read_complete = 0;
        wr_req = 1; auto_resp = 1;
        wait_idle(100, "t6");
        chk("t6_rd", rd_count, 1);
        chk("t6_wr", wr_count, 1);
`endif

        // Randomized jobs with noise, random delays, stray starts and resets.
        auto_resp = 1; noise_en = 1; rand_dly = 1;
        for (int j = 0; j < 40; j++) begin
            int k;
            do_start($urandom_range(0, 12), $urandom_range(0, 12));
            k = 0;
            while (busy === 1'b1 && k < 3000) begin
                rd_req     = ($urandom_range(0, 3) != 0);
                wr_req     = ($urandom_range(0, 2) != 0);
                start      = ($urandom_range(0, 15) == 0);
                img_width  = 16'($urandom_range(0, 300));
                img_height = 16'($urandom_range(0, 300));
                n_rst      = !((j % 13 == 5) && (k == 7));
                cyc();
                k++;
            end
            start = 0;
            n_rst = 1;
            checks++;
            if (k >= 3000) begin
                failures++;
                $display("FAIL rand_job%0d_wait busy=%b after %0d cycles, expected 0", j, busy, k);
            end
            cyc(2);
        end

        auto_resp = 0;
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
